// File: rtl/ama_riscv_fetch_buf.sv
// Instruction fetch buffer: issues sequential imem requests, queues in-order responses, feeds decode.
// Define FETCH_BUF_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module ama_riscv_fetch_buf #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_pc,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_inst,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    output logic        empty
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PW-1:0] outst_q, outst_d, drop_cnt_q, drop_cnt_d;
    logic [31:0]   dec_pc_last_q, dec_pc_last_d;

    logic [31:0]   fifo_inst_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   tag_pc_q    [DEPTH];

    logic [PW-1:0] occ;
    logic          fifo_empty, fifo_full, req_fire, drop_rsp, rsp_keep, push, fifo_pop, bypass;
    logic [31:0]   rsp_pc;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (redirect && outst_q != '0) state_d = DRAIN;
            DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drop_rsp = (state_q == DRAIN) && (drop_cnt_q != '0);
    end

    always_comb begin
        occ        = wr_ptr_q - rd_ptr_q;
        fifo_empty = rst || (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // Credits count in-flight requests so every response is guaranteed a slot.
        imem_req_valid = !rst && !redirect && (outst_q < PW'(MAX_OUTST))
                         && (({1'b0, occ} + {1'b0, outst_q}) < (PW+1)'(DEPTH));
        imem_req_pc = fetch_pc_q;
        req_fire    = imem_req_valid && imem_req_ready;
        rsp_pc      = tag_pc_q[tag_rd_q];
        rsp_keep    = imem_rsp_valid && !drop_rsp && !redirect;
`ifdef FETCH_BUF_BYPASS_EN
        bypass = fifo_empty && imem_rsp_valid && !drop_rsp;
`else
        bypass = 1'b0;
`endif
        dec_valid = !fifo_empty || bypass;
        dec_inst  = NOP;
        dec_pc    = dec_pc_last_q;
        if (!fifo_empty) begin
            dec_inst = fifo_inst_q[rd_ptr_q[AW-1:0]];
            dec_pc   = fifo_pc_q[rd_ptr_q[AW-1:0]];
        end
`ifdef FETCH_BUF_BYPASS_EN
        else if (bypass) begin
            dec_inst = imem_rsp_inst;
            dec_pc   = rsp_pc;
        end
`endif
        fifo_pop      = !fifo_empty && dec_ready;
        push          = rsp_keep && !(bypass && dec_ready);
        empty         = fifo_empty;
        dec_pc_last_d = dec_valid ? dec_pc : dec_pc_last_q;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(fifo_pop);
        tag_wr_d   = tag_wr_q + AW'(req_fire);
        tag_rd_d   = tag_rd_q + AW'(imem_rsp_valid);
        outst_d    = outst_q + PW'(req_fire) - PW'(imem_rsp_valid);
        drop_cnt_d = drop_cnt_q;
        fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        // Tag FIFO is not flushed: dropped responses still retire their tags.
        if (redirect) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_cnt_d = outst_q - PW'(imem_rsp_valid);
            fetch_pc_d = redirect_pc;
        end else if (imem_rsp_valid && drop_rsp) begin
            drop_cnt_d = drop_cnt_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            outst_q       <= '0;
            drop_cnt_q    <= '0;
            dec_pc_last_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            outst_q       <= outst_d;
            drop_cnt_q    <= drop_cnt_d;
            dec_pc_last_q <= dec_pc_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q[AW-1:0]] <= imem_rsp_inst;
            fifo_pc_q[wr_ptr_q[AW-1:0]]   <= rsp_pc;
        end
        if (req_fire) tag_pc_q[tag_wr_q] <= fetch_pc_q;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_full && !fifo_pop))
                else $error("fetch buffer push while full");
            assert (!(imem_rsp_valid && outst_q == '0))
                else $error("imem response with no request outstanding");
            assert (!(redirect && redirect_pc[1:0] != 2'b00))
                else $error("misaligned redirect_pc %h", redirect_pc);
        end
    end
`endif

endmodule

// File: tb/tb_ama_riscv_fetch_buf.sv
// Randomized bench for ama_riscv_fetch_buf against a queue-based model of the fetch stream.
module tb_ama_riscv_fetch_buf;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk, rst, redirect, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        dec_valid, dec_ready, empty;
    logic [31:0] redirect_pc, imem_req_pc, imem_rsp_inst, dec_inst, dec_pc;

    ama_riscv_fetch_buf #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_pc(imem_req_pc), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_inst(imem_rsp_inst),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready),
        .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    req_t        pend[$];    // requests accepted by imem, oldest first
    ent_t        fifo_m[$];  // instructions waiting for decode
    logic [31:0] m_fetch_pc, m_last_pc, seq_pc;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h5A3C_9617;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        fifo_m.delete();
        m_fetch_pc = RESET_PC;
        m_last_pc  = 32'h0;
        seq_pc     = RESET_PC;
    endtask

    // Drive one cycle at the negedge, check outputs just after, advance the model at the posedge.
    task automatic do_cycle(input logic rs, input logic rdir, input logic [31:0] rpc,
                            input logic rdy, input logic rspv, input logic drdy);
        bit          byp, exp_rv, exp_dv, consumed, keep;
        logic [31:0] exp_inst, exp_pc;
        req_t        r;
        rst            = rs;
        redirect       = rdir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        dec_ready      = drdy;
        imem_rsp_valid = rspv && (pend.size() > 0) && !rs;
        if (imem_rsp_valid) imem_rsp_inst = inst_of(pend[0].pc);
        else                imem_rsp_inst = $urandom;
        #1;
        if (rs) begin
            check_eq("rst_req_valid", imem_req_valid, 0);
            check_eq("rst_dec_valid", dec_valid, 0);
            check_eq("rst_dec_inst", dec_inst, NOP);
            check_eq("rst_dec_pc", dec_pc, 32'h0);
            check_eq("rst_empty", empty, 1);
            model_reset();
        end else begin
            byp = 0;
`ifdef FETCH_BUF_BYPASS_EN
            byp = (fifo_m.size() == 0) && imem_rsp_valid && !pend[0].stale;
`endif
            exp_rv = !rdir && (pend.size() < MAX_OUTST) && (fifo_m.size() + pend.size() < DEPTH);
            exp_dv = (fifo_m.size() > 0) || byp;
            if (fifo_m.size() > 0) begin
                exp_inst = fifo_m[0].inst;
                exp_pc   = fifo_m[0].pc;
            end else if (byp) begin
                exp_inst = inst_of(pend[0].pc);
                exp_pc   = pend[0].pc;
            end else begin
                exp_inst = NOP;
                exp_pc   = m_last_pc;
            end
            check_eq("req_valid", imem_req_valid, exp_rv);
            check_eq("req_pc", imem_req_pc, m_fetch_pc);
            check_eq("dec_valid", dec_valid, exp_dv);
            check_eq("dec_inst", dec_inst, exp_inst);
            check_eq("dec_pc", dec_pc, exp_pc);
            check_eq("empty", empty, fifo_m.size() == 0);

            consumed = exp_dv && drdy;
            if (consumed) begin
                check_eq("seq_pc", dec_pc, seq_pc);
                seq_pc = seq_pc + 32'd4;
                if (fifo_m.size() > 0) void'(fifo_m.pop_front());
            end
            if (exp_dv) m_last_pc = exp_pc;
            if (imem_rsp_valid) begin
                r    = pend.pop_front();
                keep = !r.stale && !rdir;
                if (keep && !(byp && consumed)) fifo_m.push_back('{r.pc, inst_of(r.pc)});
            end
            if (rdir) begin
                fifo_m.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                m_fetch_pc = rpc;
                seq_pc     = rpc;
            end else if (exp_rv && rdy) begin
                pend.push_back('{m_fetch_pc, 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rpc;
        bool_reached: begin end
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_inst = '0; dec_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        repeat (2) do_cycle(1, 0, 0, 0, 0, 0);

        // Streaming with one-cycle imem latency.
        repeat (30) do_cycle(0, 0, 0, 1, 1, 1);

        // Decode stall fills credits, then drains in order.
        repeat (10) do_cycle(0, 0, 0, 1, 1, 0);
        repeat (12) do_cycle(0, 0, 0, 1, 1, 1);

        // Build two outstanding requests, then redirect to 0x100.
        for (int i = 0; i < 20 && pend.size() < 2; i++) do_cycle(0, 0, 0, 1, 0, 1);
        if (pend.size() != 2) check_eq("wait_outst2", pend.size(), 2);
        do_cycle(0, 1, 32'h0000_0100, 1, 0, 1);
        repeat (15) do_cycle(0, 0, 0, 1, 1, 1);

        // Redirect coinciding with a response and a decode pop.
        for (int i = 0; i < 20 && !(fifo_m.size() > 0 && pend.size() > 0); i++)
            do_cycle(0, 0, 0, 1, fifo_m.size() == 0, 0);
        if (!(fifo_m.size() > 0 && pend.size() > 0)) check_eq("wait_rsp_pop", pend.size(), 1);
        do_cycle(0, 1, 32'h0000_0200, 1, 1, 1);
        repeat (15) do_cycle(0, 0, 0, 1, 1, 1);

        // Fetch PC wraps past 0xFFFF_FFFC.
        do_cycle(0, 1, 32'hFFFF_FFF8, 1, 1, 1);
        repeat (15) do_cycle(0, 0, 0, 1, 1, 1);

        repeat (3000) begin
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
            do_cycle(0, $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ama_riscv_fetch_buf.md
Name: ama_riscv_fetch_buf

Overview:
- Instruction fetch buffer: the producer side of the decoder's `inst_dec` interface.
- Issues sequential PC requests to instruction memory and absorbs in-order responses into a FIFO.
- Presents one instruction plus its PC per cycle to decode with a valid/ready handshake.
- Handles frontend redirects (branch/jalr/jal resolution) by flushing and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- MAX_OUTST, 2, max imem requests in flight; 1..DEPTH.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- redirect  in  1  frontend redirect (pc_sel/pc_we result), one-cycle pulse
- redirect_pc  in  32  new fetch PC, word-aligned
- imem_req_valid  out  1  fetch request valid
- imem_req_pc  out  32  fetch address
- imem_req_ready  in  1  imem accepts request
- imem_rsp_valid  in  1  response valid, in request order, no backpressure
- imem_rsp_inst  in  32  instruction word
- dec_valid  out  1  instruction available to decoder
- dec_inst  out  32  instruction to decoder (`inst_dec`)
- dec_pc  out  32  PC of dec_inst
- dec_ready  in  1  decode consumes this cycle
- empty  out  1  FIFO empty (debug/stall visibility)

Behaviour:
- Reset:
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0.
  - dec_valid = 0, dec_inst = 32'h0000_0013 (NOP), dec_pc = 0, imem_req_valid = 0 in the reset cycle, empty = 1.
- Request side:
  - imem_req_valid = !redirect && (outstanding < MAX_OUTST) && (occupancy + outstanding < DEPTH). The credit rule guarantees every response has a slot.
  - imem_req_pc = fetch_pc.
  - On valid && ready: fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
- Response side:
  - On imem_rsp_valid: outstanding -= 1.
  - If drop_cnt > 0: discard the response, drop_cnt -= 1.
  - Otherwise push {fetch PC tag, inst}. The PC tag is held in a parallel PC FIFO written at request acceptance.
  - Request and response in the same cycle: outstanding stays unchanged.
- Decode side:
  - dec_valid = !empty; dec_inst/dec_pc = head entry.
  - While empty: dec_inst = NOP, dec_pc holds its last value.
  - Pop on dec_valid && dec_ready. Push and pop in the same cycle: occupancy unchanged, including when full or at depth-1.
  - Latency, response to dec_valid: 1 cycle (registered FIFO).
- Redirect, highest priority:
  - Same cycle: FIFO cleared.
  - drop_cnt = outstanding minus (1 if imem_rsp_valid this cycle, else 0). The response arriving in the redirect cycle is dropped.
  - fetch_pc = redirect_pc; no request issued that cycle.
  - A pop coinciding with redirect still completes for the decoder (the instruction was handed over).
  - Redirect while drop_cnt > 0: drop_cnt is recomputed per the rule above, never double-counted.
- Pointers:
  - log2(DEPTH)+1 bits, wrap naturally.
  - full = MSBs differ, rest equal; empty = pointers equal.
- Assertions, sim only:
  - no push when full;
  - no response when outstanding == 0;
  - redirect_pc[1:0] == 0.
- State machine: IDLE (reset), RUN, DRAIN.
  - IDLE to RUN: cycle after rst deasserts.
  - RUN to DRAIN: redirect with outstanding > 0.
  - DRAIN to RUN: drop_cnt reaches 0.
  - In DRAIN, new requests are still issued at the redirect PC, subject to credits.

Optional Feature:
- FETCH_BUF_BYPASS_EN defined:
  - When FIFO empty, drop_cnt == 0 and imem_rsp_valid, the response is driven combinationally on dec_inst/dec_pc with dec_valid = 1 (0-cycle latency).
  - If dec_ready, it is not pushed; otherwise it is pushed normally.
- Undefined: strict 1-cycle registered latency; no combinational path from imem_rsp_* to dec_*.

Test Plan:
- Reset then streaming, dec_ready = 1, imem responds 1 cycle after each request -> imem_req_pc 0x0, 0x4, 0x8…; dec_pc follows the same sequence; dec_inst matches response data; no bubbles after the first fill.
- dec_ready = 0 for 10 cycles -> occupancy + outstanding reaches 4; imem_req_valid drops to 0; no push to a full FIFO; release gives in-order drain.
- Redirect to 0x100 with 2 outstanding -> next 2 responses dropped; first dec_pc after redirect = 0x100; no stale PCs reach decode.
- Redirect in the same cycle as a response and a dec pop -> popped instruction consumed once; the same-cycle response is dropped; drop_cnt = outstanding − 1.
- fetch_pc at 0xFFFF_FFFC -> next imem_req_pc = 0x0000_0000.
- FETCH_BUF_BYPASS_EN, empty FIFO, response with dec_ready = 1 -> dec_valid high in the same cycle; empty stays 1; without the macro dec_valid rises one cycle later.
